// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat table controller.
package baccarat_pkg;

  typedef enum logic [3:0] {
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    EVAL,
    DEAL_P3,
    DEALER_EVAL,
    DEAL_D3,
    DONE,
    CLEAR
  } state_e;

  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
  localparam logic [3:0] RANK_EIGHT       = 4'd8;

endpackage

// File: rtl/dealer_draw_rule.sv
// Dealer third-card decision once the player has drawn, keyed on the player's third-card rank.
module dealer_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pcard3 != RANK_EIGHT);
      4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat deal sequencer: card-load strobes, drawing rules and win lights.
// Optional win/loss/tie counters are built when BACCARAT_STATS_EN is defined.
module deal_sequencer
  import baccarat_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             clear_hand,
  output logic             player_win_light,
  output logic             dealer_win_light,
  output logic             game_done
`ifdef BACCARAT_STATS_EN
  ,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties
`endif
);

  localparam int unsigned    HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  if (CNT_W == 0) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  state_e           r_state;
  logic [HoldW-1:0] r_hold_cnt;
  logic             w_draw;
  logic             w_natural;

  assign w_natural = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);

  dealer_draw_rule u_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (w_draw)
  );

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state    <= DEAL_P1;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        DEAL_P1:     r_state <= DEAL_D1;
        DEAL_D1:     r_state <= DEAL_P2;
        DEAL_P2:     r_state <= DEAL_D2;
        DEAL_D2:     r_state <= EVAL;
        EVAL: begin
          if (w_natural)                       r_state <= DONE;
          else if (pscore < PLAYER_STAND_MIN)  r_state <= DEAL_P3;
          // Without a player draw the dealer stands on the same 6 threshold.
          else if (dscore < PLAYER_STAND_MIN)  r_state <= DEAL_D3;
          else                                 r_state <= DONE;
        end
        DEAL_P3:     r_state <= DEALER_EVAL;
        DEALER_EVAL: r_state <= w_draw ? DEAL_D3 : DONE;
        DEAL_D3:     r_state <= DONE;
        DONE: begin
          if (HOLD_CYCLES != 0) begin
            if (r_hold_cnt == HoldLast) begin
              r_state    <= CLEAR;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
        end
        CLEAR:       r_state <= DEAL_P1;
        default:     r_state <= DEAL_P1;
      endcase
    end
  end

  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    clear_hand       = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    game_done        = 1'b0;
    unique case (r_state)
      DEAL_P1: load_pcard1 = 1'b1;
      DEAL_D1: load_dcard1 = 1'b1;
      DEAL_P2: load_pcard2 = 1'b1;
      DEAL_D2: load_dcard2 = 1'b1;
      DEAL_P3: load_pcard3 = 1'b1;
      DEAL_D3: load_dcard3 = 1'b1;
      DONE: begin
        game_done        = 1'b1;
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
      end
      CLEAR:   clear_hand = 1'b1;
      default: ;
    endcase
  end

`ifdef BACCARAT_STATS_EN
  logic r_counted;

  // The first edge sampled inside DONE sees the final scores; r_counted blocks re-counting.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_counted   <= 1'b0;
      player_wins <= '0;
      dealer_wins <= '0;
      ties        <= '0;
    end else if (r_state == DONE) begin
      if (!r_counted) begin
        r_counted <= 1'b1;
        if (pscore > dscore) begin
          if (player_wins != '1) player_wins <= player_wins + 1'b1;
        end else if (dscore > pscore) begin
          if (dealer_wins != '1) dealer_wins <= dealer_wins + 1'b1;
        end else begin
          if (ties != '1) ties <= ties + 1'b1;
        end
      end
    end else begin
      r_counted <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_deal_sequencer.sv
// Randomized self-checking bench for deal_sequencer against a hand-level baccarat model.
module tb_deal_sequencer;

  localparam logic [7:0] V_NONE = 8'h00;
  localparam logic [7:0] V_P1   = 8'h80;
  localparam logic [7:0] V_D1   = 8'h40;
  localparam logic [7:0] V_P2   = 8'h20;
  localparam logic [7:0] V_D2   = 8'h10;
  localparam logic [7:0] V_P3   = 8'h08;
  localparam logic [7:0] V_D3   = 8'h04;
  localparam logic [7:0] V_CLR  = 8'h02;
  localparam logic [7:0] V_DONE = 8'h01;
  localparam int         CntMax = 255;

  logic       clk = 1'b0;
  logic       resetb;
  logic [3:0] pscore, dscore, pcard3;

  logic lp1, lp2, lp3, ld1, ld2, ld3, clr, pl, dl, done;
  logic hp1, hp2, hp3, hd1, hd2, hd3, hclr, hpl, hdl, hdone;
  logic [7:0] w_vec, h0_vec;
`ifdef BACCARAT_STATS_EN
  logic [7:0] pw, dw, tw, hpw, hdw, htw;
`endif

  int  n_total = 0;
  int  n_bad   = 0;
  bit  h0_live;
  int  exp_pw, exp_dw, exp_tie;

  always #5 clk = ~clk;

  assign w_vec  = {lp1, ld1, lp2, ld2, lp3, ld3, clr, done};
  assign h0_vec = {hp1, hd1, hp2, hd2, hp3, hd3, hclr, hdone};

  deal_sequencer #(.HOLD_CYCLES(3), .CNT_W(8)) dut (
    .slow_clock       (clk),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (lp1),
    .load_pcard2      (lp2),
    .load_pcard3      (lp3),
    .load_dcard1      (ld1),
    .load_dcard2      (ld2),
    .load_dcard3      (ld3),
    .clear_hand       (clr),
    .player_win_light (pl),
    .dealer_win_light (dl),
    .game_done        (done)
`ifdef BACCARAT_STATS_EN
    ,
    .player_wins      (pw),
    .dealer_wins      (dw),
    .ties             (tw)
`endif
  );

  // Second instance holds forever in DONE.
  deal_sequencer #(.HOLD_CYCLES(0), .CNT_W(8)) u_h0 (
    .slow_clock       (clk),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (hp1),
    .load_pcard2      (hp2),
    .load_pcard3      (hp3),
    .load_dcard1      (hd1),
    .load_dcard2      (hd2),
    .load_dcard3      (hd3),
    .clear_hand       (hclr),
    .player_win_light (hpl),
    .dealer_win_light (hdl),
    .game_done        (hdone)
`ifdef BACCARAT_STATS_EN
    ,
    .player_wins      (hpw),
    .dealer_wins      (hdw),
    .ties             (htw)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Dealer tableau after a player draw, written as rank windows that widen as dscore drops.
  function automatic bit model_draw(input int d, input int r);
    if (d <= 2) return 1'b1;
    if (d >= 7) return 1'b0;
    if (d == 3) return r != 8;
    return (r >= 2 * d - 6) && (r <= 7);
  endfunction

  function automatic int sat(input int v);
    return (v > CntMax) ? CntMax : v;
  endfunction

  task automatic check_stats();
`ifdef BACCARAT_STATS_EN
    check_eq("player_wins", pw, exp_pw);
    check_eq("dealer_wins", dw, exp_dw);
    check_eq("ties", tw, exp_tie);
`endif
  endtask

  // Called at a falling edge with the DUT in DEAL_P1; returns at a falling edge in DEAL_P1.
  task automatic play_hand(input int p2, input int d2, input int pf, input int rk, input int df,
                           input bit abort);
    logic [7:0] q[$];
    int         pfin, dfin;
    logic [1:0] res;
    pscore = 4'(p2);
    dscore = 4'(d2);
    pcard3 = 4'd0;
    q = '{V_P1, V_D1, V_P2, V_D2, V_NONE};
    pfin = p2;
    dfin = d2;
    if (!(p2 >= 8 || d2 >= 8)) begin
      if (p2 <= 5) begin
        q.push_back(V_P3);
        q.push_back(V_NONE);
        pfin = pf;
        if (model_draw(d2, rk)) begin
          q.push_back(V_D3);
          dfin = df;
        end
      end else if (d2 <= 5) begin
        q.push_back(V_D3);
        dfin = df;
      end
    end
    repeat (3) q.push_back(V_DONE);
    q.push_back(V_CLR);
    res = (pfin > dfin) ? 2'b10 : (dfin > pfin) ? 2'b01 : 2'b11;

    foreach (q[i]) begin
      check_eq("strobes", w_vec, q[i]);
      check_eq("lights", {pl, dl}, (q[i] == V_DONE) ? res : 2'b00);
      if (h0_live) check_eq("h0_seq", h0_vec, (q[i] == V_CLR) ? V_DONE : q[i]);
      else         check_eq("h0_hold", h0_vec, V_DONE);
      if (abort && q[i] == V_P3) begin
        #2 resetb = 1'b0;
        #1;
        check_eq("rst_strobes", w_vec, V_P1);
        check_eq("rst_lights", {pl, dl}, 2'b00);
        exp_pw = 0; exp_dw = 0; exp_tie = 0;
        check_stats();
        h0_live = 1'b1;
        @(negedge clk);
        resetb = 1'b1;
        return;
      end
      if (q[i] == V_P3) begin
        pscore = 4'(pf);
        pcard3 = 4'(rk);
      end
      if (q[i] == V_D3) dscore = 4'(df);
      if (q[i] == V_CLR) begin
        if (res == 2'b10)      exp_pw  = sat(exp_pw + 1);
        else if (res == 2'b01) exp_dw  = sat(exp_dw + 1);
        else                   exp_tie = sat(exp_tie + 1);
        check_stats();
        h0_live = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 1'b0;
    pscore = 4'd0;
    dscore = 4'd0;
    pcard3 = 4'd0;
    h0_live = 1'b1;
    exp_pw = 0; exp_dw = 0; exp_tie = 0;
    #3;
    check_eq("reset_strobes", w_vec, V_P1);
    check_eq("reset_lights", {pl, dl}, 2'b00);
    check_stats();
    @(negedge clk);
    resetb = 1'b1;

    play_hand(9, 3, 0, 1, 0, 1'b0);  // natural, player wins
    play_hand(7, 4, 0, 1, 7, 1'b0);  // dealer draws to a tie
    play_hand(2, 3, 5, 8, 6, 1'b0);  // dealer 3 vs rank 8 stands
    play_hand(2, 6, 1, 7, 9, 1'b0);  // dealer 6 vs rank 7 draws

    for (int d = 0; d <= 7; d++) begin
      for (int r = 1; r <= 13; r++) begin
        play_hand(2, d, int'($urandom_range(9)), r, int'($urandom_range(9)), 1'b0);
      end
    end

    play_hand(3, 1, 4, 5, 2, 1'b1);  // reset lands while in DEAL_P3

    for (int n = 0; n < 150; n++) begin
      play_hand(int'($urandom_range(9)), int'($urandom_range(9)), int'($urandom_range(9)),
                int'($urandom_range(13, 1)), int'($urandom_range(9)), 1'b0);
    end

`ifdef BACCARAT_STATS_EN
    for (int n = 0; n < 300; n++) play_hand(9, 0, 0, 1, 0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
